// File: rtl/csr_exec_unit.sv
// csr_exec_unit
//   Execution end of the CSR issue path. Each cycle it accepts one issue packet,
//   reads the source physical register (PRF answers one cycle later, with a
//   same-cycle write-back bypass), performs the Zicsr read-modify-write on a
//   small local CSR file and broadcasts the old CSR value on the common
//   dest/valid result bus.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   issue_pkt           {valid, src_tag, inst_num, rsv, Rd, ALUOP, csr_data}
//   prf_raddr           PRF read tag (combinational from issue_pkt)
//   prf_rdata           PRF data, valid during the E1 cycle
//   wb_valid/dest/data  write-back bypass sampled in the E1 cycle
//   flush               kills the op in E1 and drops the packet being issued
//   CSR_result_*        one-cycle result broadcast (old CSR value)
//   CSR_illegal         illegal access flag, qualified by CSR_result_valid
module csr_exec_unit #(
  parameter int PHYS_W = 8,
  parameter int XLEN   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2*PHYS_W+2*XLEN+5:0] issue_pkt,
  output logic [PHYS_W-1:0]          prf_raddr,
  input  logic [XLEN-1:0]            prf_rdata,
  input  logic                       wb_valid,
  input  logic [PHYS_W-1:0]          wb_dest,
  input  logic [XLEN-1:0]            wb_data,
  input  logic                       flush,
  output logic                       CSR_result_valid,
  output logic [PHYS_W-1:0]          CSR_result_dest,
  output logic [XLEN-1:0]            CSR_result_data,
  output logic [XLEN-1:0]            CSR_result_inst_num,
  output logic                       CSR_illegal
);

  localparam int OP_LSB   = XLEN;
  localparam int RD_LSB   = XLEN + 4;
  localparam int RSV_BIT  = RD_LSB + PHYS_W;
  localparam int INST_LSB = RSV_BIT + 1;
  localparam int TAG_LSB  = INST_LSB + XLEN;
  localparam int VLD_BIT  = TAG_LSB + PHYS_W;

  localparam logic [XLEN-1:0] MSTATUS_MASK = XLEN'(32'h0000_0088);

  // ALUOP[1:0]: 1 = write, 2 = set, 3 = clear (ALUOP[2] selects the zimm form)
  function automatic logic [XLEN-1:0] rmw(input logic [1:0] kind,
                                          input logic [XLEN-1:0] old_v,
                                          input logic [XLEN-1:0] opnd_v);
    case (kind)
      2'b01:   rmw = opnd_v;
      2'b10:   rmw = old_v | opnd_v;
      default: rmw = old_v & ~opnd_v;
    endcase
  endfunction

  assign prf_raddr = issue_pkt[TAG_LSB +: PHYS_W];

  logic unused_pkt_bits;
  assign unused_pkt_bits = &{1'b0, issue_pkt[RSV_BIT], issue_pkt[XLEN-1:17]};

  // ---- p0 -> p1: issue packet captured into E1 ----
  logic              vld_p1_q, vld_p1_d;
  logic [PHYS_W-1:0] tag_p1_q, rd_p1_q;
  logic [3:0]        op_p1_q;
  logic [16:0]       csr_p1_q;
  logic [XLEN-1:0]   inst_p1_q;

  // a packet arriving together with a flush is dropped
  assign vld_p1_d = issue_pkt[VLD_BIT] & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_p1_q <= 1'b0;
    else        vld_p1_q <= vld_p1_d;
  end

  always_ff @(posedge clk) begin
    tag_p1_q  <= issue_pkt[TAG_LSB +: PHYS_W];
    inst_p1_q <= issue_pkt[INST_LSB +: XLEN];
    rd_p1_q   <= issue_pkt[RD_LSB +: PHYS_W];
    op_p1_q   <= issue_pkt[OP_LSB +: 4];
    csr_p1_q  <= issue_pkt[16:0];
  end

  // ---- E1: operand select, CSR read, RMW, legality ----
  logic [XLEN-1:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [63:0]     cyc_q, cyc_d;
  logic [11:0]     addr;
  logic [XLEN-1:0] zimm, src_val, opnd, old_val, new_val;
  logic            op_ok, mapped, ro, suppress, illegal, res_vld, csr_we;

  assign cyc_d = cyc_q + 64'd1;

  always_comb begin
    addr = csr_p1_q[11:0];
    zimm = XLEN'(csr_p1_q[16:12]);
    if (tag_p1_q == '0)                          src_val = '0;
    else if (wb_valid && (wb_dest == tag_p1_q))  src_val = wb_data;
    else                                         src_val = prf_rdata;
    opnd     = op_p1_q[2] ? zimm : src_val;
    op_ok    = !op_p1_q[3] && (op_p1_q[1:0] != 2'b00);
    // set/clear with a zero operand source is a pure read
    suppress = (op_p1_q[1:0] != 2'b01) &&
               (op_p1_q[2] ? (zimm == '0) : (tag_p1_q == '0));
    mapped   = 1'b1;
    ro       = 1'b0;
    old_val  = '0;
    case (addr)
      12'h300: old_val = mstatus_q;
      12'h304: old_val = mie_q;
      12'h305: old_val = mtvec_q;
      12'h340: old_val = mscratch_q;
      12'h341: old_val = mepc_q;
      12'h342: old_val = mcause_q;
      12'hC00: begin old_val = cyc_q[31:0];  ro = 1'b1; end
      12'hC80: begin old_val = cyc_q[63:32]; ro = 1'b1; end
      default: mapped = 1'b0;
    endcase
    illegal = !op_ok || !mapped || (ro && !suppress);
    res_vld = vld_p1_q && !flush;
    csr_we  = res_vld && !illegal && !suppress;
    new_val = rmw(op_p1_q[1:0], old_val, opnd);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q      <= '0;
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      cyc_q <= cyc_d;
      if (csr_we) begin
        case (addr)
          12'h300: mstatus_q  <= new_val & MSTATUS_MASK;
          12'h304: mie_q      <= new_val;
          12'h305: mtvec_q    <= new_val;
          12'h340: mscratch_q <= new_val;
          12'h341: mepc_q     <= new_val;
          12'h342: mcause_q   <= new_val;
          default: ;
        endcase
      end
    end
  end

  // ---- p1 -> p2: result broadcast ----
  logic              res_vld_q, res_ill_q;
  logic [PHYS_W-1:0] res_dest_q;
  logic [XLEN-1:0]   res_data_q, res_inst_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_vld_q  <= 1'b0;
      res_ill_q  <= 1'b0;
      res_dest_q <= '0;
      res_data_q <= '0;
      res_inst_q <= '0;
    end else begin
      res_vld_q <= res_vld;
      res_ill_q <= res_vld && illegal;
      if (res_vld) begin
        res_dest_q <= rd_p1_q;
        res_data_q <= illegal ? '0 : old_val;
        res_inst_q <= inst_p1_q;
      end
    end
  end

  assign CSR_result_valid    = res_vld_q;
  assign CSR_illegal         = res_ill_q;
  assign CSR_result_dest     = res_dest_q;
  assign CSR_result_data     = res_data_q;
  assign CSR_result_inst_num = res_inst_q;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Testbench for csr_exec_unit: directed scenarios followed by randomized
// traffic, all checked against a transaction-level CSR model.
module tb_csr_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [85:0] issue_pkt;
  logic [7:0]  prf_raddr;
  logic [31:0] prf_rdata;
  logic        wb_valid;
  logic [7:0]  wb_dest;
  logic [31:0] wb_data;
  logic        flush;
  logic        CSR_result_valid;
  logic [7:0]  CSR_result_dest;
  logic [31:0] CSR_result_data;
  logic [31:0] CSR_result_inst_num;
  logic        CSR_illegal;

  always #5 clk = ~clk;

  csr_exec_unit #(.PHYS_W(8), .XLEN(32)) dut (
    .clk                 (clk),
    .reset               (reset),
    .issue_pkt           (issue_pkt),
    .prf_raddr           (prf_raddr),
    .prf_rdata           (prf_rdata),
    .wb_valid            (wb_valid),
    .wb_dest             (wb_dest),
    .wb_data             (wb_data),
    .flush               (flush),
    .CSR_result_valid    (CSR_result_valid),
    .CSR_result_dest     (CSR_result_dest),
    .CSR_result_data     (CSR_result_data),
    .CSR_result_inst_num (CSR_result_inst_num),
    .CSR_illegal         (CSR_illegal)
  );

  // physical register file: answers one cycle after the address
  logic [31:0] prf [256];
  always @(posedge clk) prf_rdata <= prf[prf_raddr];

  // clocks elapsed since reset release
  logic [63:0] cyc_m;
  always @(posedge clk or negedge reset)
    if (!reset) cyc_m <= 64'd0;
    else        cyc_m <= cyc_m + 64'd1;

  typedef struct {
    bit          v;
    logic [7:0]  tag;
    logic [7:0]  rd;
    logic [3:0]  op;
    logic [31:0] cd;
    logic [31:0] inst;
  } pkt_t;

  logic [31:0] csr_m [logic [11:0]];
  pkt_t        e1;
  bit          e1_v;
  bit          exp_v, exp_ill;
  logic [7:0]  exp_dest;
  logic [31:0] exp_data, exp_inst;
  int          inst_ctr;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic pkt_t mk(input logic [3:0] op, input logic [11:0] addr,
                              input logic [7:0] tag, input logic [4:0] zimm,
                              input logic [7:0] rd);
    pkt_t p;
    logic [31:0] r;
    r      = $urandom();
    p.v    = 1'b1;
    p.tag  = tag;
    p.rd   = rd;
    p.op   = op;
    p.cd   = {r[14:0], zimm, addr};
    inst_ctr++;
    p.inst = inst_ctr;
    return p;
  endfunction

  function automatic pkt_t nop();
    pkt_t p;
    p      = mk(4'($urandom_range(0, 15)), 12'h340, 8'($urandom()), 5'd7, 8'd1);
    p.v    = 1'b0;
    return p;
  endfunction

  task automatic model_reset();
    csr_m.delete();
    csr_m[12'h300] = 0; csr_m[12'h304] = 0; csr_m[12'h305] = 0;
    csr_m[12'h340] = 0; csr_m[12'h341] = 0; csr_m[12'h342] = 0;
    e1_v  = 0;
    exp_v = 0;
  endtask

  // One clock: check the broadcast of the previous edge, drive new inputs,
  // then evaluate the op sitting in E1 under these inputs.
  task automatic step(input pkt_t p, input bit fl, input bit wv,
                      input logic [7:0] wd, input logic [31:0] wdat);
    logic [31:0] src, zi, opnd, old, nv;
    logic [11:0] a;
    bit          bad, wr, ro;
    @(negedge clk);
    check("valid", CSR_result_valid, exp_v);
    if (exp_v) begin
      check("dest", CSR_result_dest, exp_dest);
      check("inst", CSR_result_inst_num, exp_inst);
      check("illegal", CSR_illegal, exp_ill);
      check("data", CSR_result_data, exp_data);
    end
    issue_pkt = {p.v, p.tag, p.inst, 1'b0, p.rd, p.op, p.cd};
    flush     = fl;
    wb_valid  = wv;
    wb_dest   = wd;
    wb_data   = wdat;
    exp_v     = 0;
    if (e1_v && !fl) begin
      a    = e1.cd[11:0];
      zi   = {27'd0, e1.cd[16:12]};
      src  = (e1.tag == 0) ? 32'd0 : (wv && wd == e1.tag) ? wdat : prf[e1.tag];
      opnd = (e1.op >= 5) ? zi : src;
      bad  = !(e1.op inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7});
      wr   = (e1.op == 1 || e1.op == 5) || ((e1.op < 4) ? (e1.tag != 0) : (zi != 0));
      ro   = (a == 12'hC00 || a == 12'hC80);
      old  = 0;
      if (a == 12'hC00)         old = cyc_m[31:0];
      else if (a == 12'hC80)    old = cyc_m[63:32];
      else if (csr_m.exists(a)) old = csr_m[a];
      else                      bad = 1;
      if (ro && wr) bad = 1;
      if (!bad && wr) begin
        case (e1.op)
          4'd1, 4'd5: nv = opnd;
          4'd2, 4'd6: nv = old | opnd;
          default:    nv = old & ~opnd;
        endcase
        if (a == 12'h300) nv = nv & 32'h88;
        csr_m[a] = nv;
      end
      exp_v    = 1;
      exp_dest = e1.rd;
      exp_inst = e1.inst;
      exp_ill  = bad;
      exp_data = bad ? 32'd0 : old;
    end
    e1_v = p.v && !fl;
    e1   = p;
  endtask

  task automatic idle();
    step(nop(), 0, 0, 8'd0, 32'd0);
  endtask

  task automatic run(input pkt_t p);
    step(p, 0, 0, 8'd0, 32'd0);
    idle();
    idle();
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    issue_pkt = '0;
    flush     = 0;
    wb_valid  = 0;
    wb_dest   = 0;
    wb_data   = 0;
    #1;
    check("rst_valid", CSR_result_valid, 0);
    check("rst_illegal", CSR_illegal, 0);
    check("rst_data", CSR_result_data, 0);
    check("rst_dest", CSR_result_dest, 0);
    check("rst_inst", CSR_result_inst_num, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    pkt_t        p;
    logic [11:0] addrs [9];
    logic [7:0]  t;
    logic [4:0]  z;
    bit          fl, wv;
    logic [7:0]  wd;
    reset    = 1'b0;
    inst_ctr = 100;
    for (int i = 0; i < 256; i++) prf[i] = $urandom();
    prf[5] = 32'hDEADBEEF;
    prf[6] = 32'hFFFFFFFF;
    prf[7] = 32'h0;
    prf[8] = 32'h55;
    addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'hC00, 12'hC80, 12'h000};

    do_reset();

    // counter read during the 10th cycle after release
    repeat (7) idle();
    step(mk(4'd2, 12'hC00, 8'd0, 5'd0, 8'd3), 0, 0, 8'd0, 32'd0);
    idle();
    idle();
    check("cycle9", CSR_result_data, 32'd9);
    run(mk(4'd1, 12'hC00, 8'd5, 5'd0, 8'd3));
    check("ro_illegal", CSR_illegal, 1);
    check("ro_data", CSR_result_data, 0);

    // CSRRW then pure-read CSRRS on mscratch
    run(mk(4'd1, 12'h340, 8'd5, 5'd0, 8'd9));
    check("rw_old", CSR_result_data, 0);
    check("rw_dest", CSR_result_dest, 8'd9);
    run(mk(4'd2, 12'h340, 8'd0, 5'd0, 8'd0));
    check("rs_read", CSR_result_data, 32'hDEADBEEF);
    check("rd0_valid", CSR_result_valid, 1);
    run(mk(4'd2, 12'h340, 8'd0, 5'd0, 8'd4));
    check("rs_nowrite", CSR_result_data, 32'hDEADBEEF);

    // back-to-back RMW on mie
    step(mk(4'd6, 12'h304, 8'd0, 5'd3, 8'd2), 0, 0, 8'd0, 32'd0);
    step(mk(4'd7, 12'h304, 8'd0, 5'd1, 8'd2), 0, 0, 8'd0, 32'd0);
    idle();
    check("b2b_first", CSR_result_data, 32'h0);
    idle();
    check("b2b_second", CSR_result_data, 32'h3);
    idle();
    run(mk(4'd2, 12'h304, 8'd0, 5'd0, 8'd2));
    check("mie_final", CSR_result_data, 32'h2);

    // mstatus write mask
    run(mk(4'd1, 12'h300, 8'd6, 5'd0, 8'd2));
    run(mk(4'd2, 12'h300, 8'd0, 5'd0, 8'd2));
    check("mstatus_mask", CSR_result_data, 32'h88);

    // bypass wins over PRF
    step(mk(4'd1, 12'h341, 8'd7, 5'd0, 8'd2), 0, 0, 8'd0, 32'd0);
    step(nop(), 0, 1, 8'd7, 32'h1234);
    idle();
    run(mk(4'd2, 12'h341, 8'd0, 5'd0, 8'd2));
    check("bypass_mepc", CSR_result_data, 32'h1234);

    // flush in E1
    step(mk(4'd1, 12'h342, 8'd8, 5'd0, 8'd2), 0, 0, 8'd0, 32'd0);
    step(nop(), 1, 0, 8'd0, 32'd0);
    idle();
    check("flush_novalid", CSR_result_valid, 0);
    run(mk(4'd2, 12'h342, 8'd0, 5'd0, 8'd2));
    check("flush_mcause", CSR_result_data, 32'h0);

    // asynchronous reset with an op in E1
    step(mk(4'd1, 12'h305, 8'd5, 5'd0, 8'd2), 0, 0, 8'd0, 32'd0);
    idle();
    do_reset();
    idle();
    idle();
    check("rst_lost", CSR_result_valid, 0);
    run(mk(4'd2, 12'h340, 8'd0, 5'd0, 8'd2));
    check("rst_mscratch", CSR_result_data, 32'h0);
    run(mk(4'd2, 12'h305, 8'd0, 5'd0, 8'd2));
    check("rst_mtvec", CSR_result_data, 32'h0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      t  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      z  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      p  = mk(4'($urandom_range(0, 15)),
              (($urandom_range(0, 8) == 8) ? 12'($urandom()) : addrs[$urandom_range(0, 7)]),
              t, z, 8'($urandom()));
      if ($urandom_range(0, 4) == 0) p.v = 0;
      fl = ($urandom_range(0, 9) == 0);
      wv = ($urandom_range(0, 2) == 0);
      wd = ($urandom_range(0, 1) == 0) ? e1.tag : 8'($urandom());
      step(p, fl, wv, wd, $urandom());
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
